mseq_ber_checker: RTL and testbench

MSEQ_BER_CHECKER -- requirements
Module: mseq_ber_checker

---
 rtl/mseq_ber_checker_pkg.sv | 21 ++
 rtl/mseq_ber_checker_pn_lfsr.sv | 29 ++
 rtl/mseq_ber_checker.sv | 145 ++++++++++++++
 tb/tb_mseq_ber_checker.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mseq_ber_checker_pkg.sv
// Shared types and defaults for the PN-sequence BER checker and its
// PN generator.
package mseq_ber_checker_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } mseq_state_e;

  // x^7 + x^6 + 1: feedback taps on the two oldest bits.
  localparam logic [6:0] PN_TAPS = 7'h60;

  localparam int DEF_LFSR_W         = 7;
  localparam int DEF_VERIFY_LEN     = 32;
  localparam int DEF_VERIFY_MAX_ERR = 2;
  localparam int DEF_WINDOW_LEN     = 1024;
  localparam int DEF_LOSS_THRESH    = 64;
  localparam int DEF_CNT_W          = 32;

endpackage

// File: rtl/mseq_ber_checker_pn_lfsr.sv
// Fibonacci PN generator. shift_in_i=1 loads received bits (seeding),
// shift_in_i=0 runs free on its own feedback (flywheel / transmit source).
module pn_lfsr
  import mseq_ber_checker_pkg::*;
#(
  parameter int             W    = DEF_LFSR_W,
  parameter logic [W-1:0]   TAPS = W'(PN_TAPS)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         shift_in_i,
  input  logic         din_i,
  output logic [W-1:0] nxt_o,
  output logic         pred_o
);

  logic [W-1:0] lfsr_q, lfsr_d;

  assign pred_o = ^(lfsr_q & TAPS);
  assign lfsr_d = {lfsr_q[W-2:0], (shift_in_i ? din_i : pred_o)};
  assign nxt_o  = lfsr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i)     lfsr_q <= '0;
    else if (en_i) lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/mseq_ber_checker.sv
// PN bit-error-rate checker: seeds a local PN generator from the received
// stream, verifies alignment, then counts bit errors per window and overall.
module mseq_ber_checker
  import mseq_ber_checker_pkg::*;
#(
  parameter int LFSR_W         = DEF_LFSR_W,
  parameter int VERIFY_LEN     = DEF_VERIFY_LEN,
  parameter int VERIFY_MAX_ERR = DEF_VERIFY_MAX_ERR,
  parameter int WINDOW_LEN     = DEF_WINDOW_LEN,
  parameter int LOSS_THRESH    = DEF_LOSS_THRESH,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                             receiver_clk,
  input  logic                             receiver_rst,
  input  logic                             data_i,
  input  logic                             data_valid_i,
  input  logic                             clear_i,
  output logic                             locked_o,
  output logic [CNT_W-1:0]                 bit_cnt_o,
  output logic [CNT_W-1:0]                 err_cnt_o,
  output logic                             window_done_o,
  output logic [$clog2(WINDOW_LEN+1)-1:0]  err_window_o
);

  localparam int LC_W = $clog2(LFSR_W + 1);
  localparam int VC_W = $clog2(VERIFY_LEN + 1);
  localparam int WC_W = $clog2(WINDOW_LEN);
  localparam int WE_W = $clog2(WINDOW_LEN + 1);

  mseq_state_e      state_q, state_d;
  logic [LC_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [VC_W-1:0]  vf_cnt_q, vf_cnt_d, vf_err_q, vf_err_d, vf_err_nxt;
  logic [WC_W-1:0]  win_cnt_q, win_cnt_d;
  logic [WE_W-1:0]  win_err_q, win_err_d, win_err_nxt, err_win_q, err_win_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, err_cnt_q, err_cnt_d;
  logic             locked_q, wdone_q, wdone_d;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic             pred, mism;

  pn_lfsr #(.W(LFSR_W), .TAPS(LFSR_W'(PN_TAPS))) u_pn (
    .clk_i      (receiver_clk),
    .rst_i      (receiver_rst),
    .en_i       (data_valid_i),
    .shift_in_i (state_q == ST_LOAD),
    .din_i      (data_i),
    .nxt_o      (lfsr_nxt),
    .pred_o     (pred)
  );

  assign mism        = data_i ^ pred;
  assign vf_err_nxt  = vf_err_q + VC_W'(mism);
  assign win_err_nxt = win_err_q + WE_W'(mism);

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    vf_cnt_d  = vf_cnt_q;
    vf_err_d  = vf_err_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    err_win_d = err_win_q;
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    wdone_d   = 1'b0;
    if (data_valid_i) begin
      case (state_q)
        ST_LOAD: begin
          if (ld_cnt_q == LC_W'(LFSR_W - 1)) begin
            ld_cnt_d = '0;
            // An all-zero seed would lock the flywheel at zero forever.
            if (lfsr_nxt != '0) state_d = ST_VERIFY;
          end else begin
            ld_cnt_d = ld_cnt_q + LC_W'(1);
          end
        end
        ST_VERIFY: begin
          if (vf_cnt_q == VC_W'(VERIFY_LEN - 1)) begin
            vf_cnt_d  = '0;
            vf_err_d  = '0;
            win_cnt_d = '0;
            win_err_d = '0;
            state_d   = (vf_err_nxt <= VC_W'(VERIFY_MAX_ERR)) ? ST_LOCKED : ST_LOAD;
          end else begin
            vf_cnt_d = vf_cnt_q + VC_W'(1);
            vf_err_d = vf_err_nxt;
          end
        end
        ST_LOCKED: begin
          if (bit_cnt_q != '1)         bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (mism && err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          if (win_cnt_q == WC_W'(WINDOW_LEN - 1)) begin
            err_win_d = win_err_nxt;
            wdone_d   = 1'b1;
            win_cnt_d = '0;
            win_err_d = '0;
            if (win_err_nxt >= WE_W'(LOSS_THRESH)) state_d = ST_LOAD;
          end else begin
            win_cnt_d = win_cnt_q + WC_W'(1);
            win_err_d = win_err_nxt;
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
    if (clear_i) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge receiver_clk) begin
    if (receiver_rst) begin
      state_q   <= ST_LOAD;
      ld_cnt_q  <= '0;
      vf_cnt_q  <= '0;
      vf_err_q  <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      err_win_q <= '0;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
      locked_q  <= 1'b0;
      wdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      vf_cnt_q  <= vf_cnt_d;
      vf_err_q  <= vf_err_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      err_win_q <= err_win_d;
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
      locked_q  <= (state_d == ST_LOCKED);
      wdone_q   <= wdone_d;
    end
  end

  assign locked_o      = locked_q;
  assign bit_cnt_o     = bit_cnt_q;
  assign err_cnt_o     = err_cnt_q;
  assign window_done_o = wdone_q;
  assign err_window_o  = err_win_q;

endmodule

// File: tb/tb_mseq_ber_checker.sv
// Directed bench for the PN BER checker: lock, windowed errors, loss of lock,
// zero-seed rejection, counter clear and mid-lock reset.
module tb_mseq_ber_checker;

  logic        clk = 1'b0;
  logic        rst, data, dv, clr;
  logic        locked;
  logic [31:0] bit_cnt, err_cnt;
  logic        wdone;
  logic [10:0] err_win;

  int checks = 0;
  int errors = 0;
  int wd_cnt = 0;
  int relock = 0;
  int wd_base;
  logic [6:0] g;

  always #5 clk = ~clk;

  mseq_ber_checker dut (
    .receiver_clk  (clk),
    .receiver_rst  (rst),
    .data_i        (data),
    .data_valid_i  (dv),
    .clear_i       (clr),
    .locked_o      (locked),
    .bit_cnt_o     (bit_cnt),
    .err_cnt_o     (err_cnt),
    .window_done_o (wdone),
    .err_window_o  (err_win)
  );

  always @(negedge clk) if (wdone === 1'b1) wd_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference PN source: emits g[6], recurrence s[n] = s[n-7] ^ s[n-6].
  task automatic pn_bit(output logic b);
    b = g[6];
    g = {g[5:0], g[6] ^ g[5]};
  endtask

  // One valid strobe every 4 cycles.
  task automatic send_bit(input logic b);
    @(negedge clk); data = b; dv = 1'b1;
    @(negedge clk); dv = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_pn(input logic inv);
    logic b;
    pn_bit(b);
    send_bit(b ^ inv);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_bitcnt"}, bit_cnt, 0);
    chk({tag, "_errcnt"}, err_cnt, 0);
    chk({tag, "_wdone"},  32'(wdone), 0);
    chk({tag, "_errwin"}, 32'(err_win), 0);
  endtask

  initial begin
    logic b;
    rst = 1'b1; data = 1'b0; dv = 1'b0; clr = 1'b0; g = 7'h7F;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Error-free PN from seed 7F: lock after exactly 7+32 valid bits.
    repeat (38) send_pn(1'b0);
    chk("s1_unlocked_at_38", 32'(locked), 0);
    send_pn(1'b0);
    chk("s1_locked_at_39", 32'(locked), 1);
    chk("s1_errcnt", err_cnt, 0);
    chk("s1_bitcnt", bit_cnt, 0);

    // 2048 bits, every 100th inverted: 10 errors per window.
    for (int k = 1; k <= 2048; k++) begin
      send_pn(k % 100 == 0);
      if (k == 1024) begin
        chk("s2_wd_first", 32'(wd_cnt), 1);
        chk("s2_errwin_first", 32'(err_win), 10);
      end
    end
    chk("s2_wd_second", 32'(wd_cnt), 2);
    chk("s2_errwin_second", 32'(err_win), 10);
    chk("s2_errcnt", err_cnt, 20);
    chk("s2_bitcnt", bit_cnt, 2048);
    chk("s2_locked", 32'(locked), 1);

    // Inverted stream: lock only drops at the window boundary.
    repeat (1023) send_pn(1'b1);
    chk("s3_hold_1023", 32'(locked), 1);
    chk("s3_errcnt_1023", err_cnt, 1043);
    send_pn(1'b1);
    chk("s3_lost", 32'(locked), 0);
    chk("s3_errwin", 32'(err_win), 1024);
    chk("s3_wd", 32'(wd_cnt), 3);
    chk("s3_errcnt", err_cnt, 1044);
    chk("s3_bitcnt", bit_cnt, 3072);
    for (int k = 0; k < 300; k++) begin
      send_pn(1'b1);
      if (locked !== 1'b0) relock++;
    end
    chk("s3_no_relock", 32'(relock), 0);
    chk("s3_bitcnt_hold", bit_cnt, 3072);
    chk("s3_errwin_hold", 32'(err_win), 1024);
    chk("s3_wd_hold", 32'(wd_cnt), 3);

    // Reset overrides concurrent clear and valid.
    @(negedge clk); rst = 1'b1; clr = 1'b1; dv = 1'b1; data = 1'b1;
    @(negedge clk); rst = 1'b0; clr = 1'b0; dv = 1'b0;
    chk_all_zero("s4_reset");

    // Seven zeros are rejected as a seed; lock 39 bits after PN start.
    g = 7'h01;
    repeat (7) send_bit(1'b0);
    repeat (38) send_pn(1'b0);
    chk("s4_unlocked_at_38", 32'(locked), 0);
    send_pn(1'b0);
    chk("s4_locked_at_39", 32'(locked), 1);

    // Clear wins over a coincident valid bit; LFSR still advances.
    repeat (500) send_pn(1'b0);
    chk("s5_bitcnt_500", bit_cnt, 500);
    pn_bit(b);
    @(negedge clk); data = b; dv = 1'b1; clr = 1'b1;
    @(negedge clk); dv = 1'b0; clr = 1'b0;
    chk("s5_clear", bit_cnt, 0);
    chk("s5_locked", 32'(locked), 1);
    send_pn(1'b0);
    chk("s5_bitcnt_1", bit_cnt, 1);
    chk("s5_errcnt", err_cnt, 0);

    // Reset mid-window discards the partial window and the lock.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk_all_zero("s6_reset");
    repeat (38) send_pn(1'b0);
    chk("s6_unlocked_at_38", 32'(locked), 0);
    send_pn(1'b0);
    chk("s6_locked_at_39", 32'(locked), 1);
    wd_base = wd_cnt;
    for (int k = 1; k <= 1023; k++) send_pn(k == 512);
    chk("s6_no_early_window", 32'(wd_cnt), 32'(wd_base));
    send_pn(1'b0);
    chk("s6_window", 32'(wd_cnt), 32'(wd_base + 1));
    chk("s6_errwin", 32'(err_win), 1);
    chk("s6_errcnt", err_cnt, 1);
    chk("s6_bitcnt", bit_cnt, 1024);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
